out_channel_streamer: RTL

- Downstream consumer of a test program's output channel.
- Captures each word the program's `out` instruction emits, one push per clock, and buffers it in a small FIFO.
- Replays the words on a valid/ready stream toward a host or checker, and marks the final word once the program signals finished.
- Provides drained / overflow status so a board-level harness knows when the output capture is complete and trustworthy.

---
 rtl/out_channel_streamer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/out_channel_streamer.sv
// Output-channel capture FIFO with a first-word-fall-through valid/ready replay stream.
// Optional rotate-XOR checksum of delivered words: define OUT_CHANNEL_STREAMER_CHECKSUM_EN.
module out_channel_streamer #(
   parameter int MemoryElementWidth = 12,
   parameter int Depth              = 8,
   parameter int CountWidth         = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          outWrite,
   input  logic [MemoryElementWidth-1:0] outData,
   output logic                          outFull,
   input  logic                          finishedIn,
   output logic                          streamValid,
   output logic [MemoryElementWidth-1:0] streamData,
   input  logic                          streamReady,
   output logic                          streamLast,
   output logic [CountWidth-1:0]         wordsOut,
   output logic                          overflow,
   output logic                          drained,
`ifdef OUT_CHANNEL_STREAMER_CHECKSUM_EN
   output logic [MemoryElementWidth-1:0] checksum,
`endif
   output logic [1:0]                    state_dbg
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);

   // Stream handshake: a word transfers on every rising edge where
   // streamValid && streamReady; streamValid never drops and streamData never
   // changes while a word is offered but not yet taken.

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_CLOSING = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   state_e                        state_q, state_d;
   logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]               count_q, count_d;
   logic [CountWidth-1:0]         words_q, words_d;
   logic                          overflow_q, overflow_d;
   logic [MemoryElementWidth-1:0] mem_q [Depth];
   logic                          pop;
   logic                          push_ok;
   logic                          closing;

   assign closing = (state_q != ST_RUN);

   always_comb begin
      pop        = (count_q != '0) && streamReady;
      // A full FIFO can still take a word if the head leaves in the same cycle.
      push_ok    = outWrite && !closing && ((count_q != DEPTH_C) || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      words_d    = words_q;
      overflow_d = overflow_q | (outWrite & ~push_ok);
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
         words_d  = words_q + CountWidth'(1);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Closing is entered on the first finishedIn; drained follows once closing
   // is already in effect and the FIFO has emptied.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:     if (finishedIn) state_d = ST_CLOSING;
         ST_CLOSING: if (count_d == '0) state_d = ST_DONE;
         ST_DONE:    state_d = ST_DONE;
         default:    state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         words_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         words_q    <= words_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is intentionally left uninitialised; the count gates visibility.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= outData;
      end
   end

`ifdef OUT_CHANNEL_STREAMER_CHECKSUM_EN
   logic [MemoryElementWidth-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (pop && (state_q != ST_DONE)) begin
         checksum_d = {checksum_q[MemoryElementWidth-2:0], checksum_q[MemoryElementWidth-1]}
                      ^ mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

   assign outFull     = (count_q == DEPTH_C);
   assign streamValid = (count_q != '0);
   assign streamData  = mem_q[rd_ptr_q];
   assign streamLast  = streamValid && closing && (count_q == CntW'(1));
   assign wordsOut    = words_q;
   assign overflow    = overflow_q;
   assign drained     = (state_q == ST_DONE);
   assign state_dbg   = state_q;

endmodule
